// File: rtl/draw_datapath.sv
// Pixel-streaming datapath for the game's draw commands: bird, wall, clear.
// One scan slot per cycle; skipped slots hold plot low but still take their cycle.
module draw_datapath #(
  parameter int unsigned BIRD_X      = 20,
  parameter int unsigned BIRD_SIZE   = 4,
  parameter int unsigned WALL_W      = 8,
  parameter int unsigned GAP_H       = 40,
  parameter logic [2:0]  BG_COLOUR   = 3'b011,
  parameter logic [2:0]  BIRD_COLOUR = 3'b110,
  parameter logic [2:0]  WALL_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_DRAW_BIRD, OP_ERASE_BIRD, OP_DRAW_WALL, OP_ERASE_WALL, OP_CLEAR
  } op_e;

  function automatic op_e decode(input logic [3:0] code);
    case (code)
      4'b1111: return OP_DRAW_WALL;
      4'b1110: return OP_DRAW_BIRD;
      4'b1100: return OP_ERASE_WALL;
      4'b1101: return OP_ERASE_BIRD;
      4'b0001: return OP_CLEAR;
      default: return OP_NOP;
    endcase
  endfunction

  state_e     state_q;
  op_e        op_q;
  logic [6:0] bird_y_q;
  logic [7:0] wall_x_q;
  logic [6:0] gap_y_q;
  logic [7:0] col_q;
  logic [6:0] row_q;
  logic       fin_q;
  logic       ready_q;
  logic       plot_q;
  logic       done_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;

  logic [7:0] col_last;
  logic [6:0] row_last;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_on;
  logic [7:0] bird_row;
  logic [8:0] wall_col;
  logic [7:0] gap_end;
  logic       in_gap;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    col_last   = 8'd0;
    row_last   = 7'd0;
    pix_x      = col_q;
    pix_y      = row_q;
    pix_colour = BG_COLOUR;
    pix_on     = 1'b0;
    bird_row   = {1'b0, bird_y_q} + {1'b0, row_q};
    wall_col   = {1'b0, wall_x_q} + {1'b0, col_q};
    gap_end    = {1'b0, gap_y_q} + 8'(GAP_H);
    in_gap     = ({1'b0, row_q} >= {1'b0, gap_y_q}) && ({1'b0, row_q} < gap_end);
    case (op_q)
      OP_DRAW_BIRD, OP_ERASE_BIRD: begin
        col_last   = 8'(BIRD_SIZE - 1);
        row_last   = 7'(BIRD_SIZE - 1);
        pix_x      = 8'(BIRD_X) + col_q;
        pix_y      = bird_row[6:0];
        pix_colour = (op_q == OP_DRAW_BIRD) ? BIRD_COLOUR : BG_COLOUR;
        pix_on     = (bird_row <= 8'd119);
      end
      OP_DRAW_WALL, OP_ERASE_WALL: begin
        col_last   = 8'(WALL_W - 1);
        row_last   = 7'd119;
        pix_x      = wall_col[7:0];
        pix_colour = (op_q == OP_DRAW_WALL) ? WALL_COLOUR : BG_COLOUR;
        // Columns past the right edge are dropped rather than wrapped.
        pix_on     = (wall_col < 9'd160) && !((op_q == OP_DRAW_WALL) && in_gap);
      end
      OP_CLEAR: begin
        col_last = 8'd159;
        row_last = 7'd119;
        pix_on   = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      bird_y_q <= '0;
      wall_x_q <= '0;
      gap_y_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fin_q    <= 1'b0;
      ready_q  <= 1'b1;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q  <= S_RUN;
            op_q     <= decode(cmd);
            bird_y_q <= bird_y;
            wall_x_q <= wall_x;
            gap_y_q  <= gap_y;
            col_q    <= '0;
            row_q    <= '0;
            fin_q    <= (decode(cmd) == OP_NOP);
            ready_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (fin_q) begin
            state_q <= S_IDLE;
            fin_q   <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            plot_q <= pix_on;
            // Pixel outputs only move on a real write so they stay stable while plot is low.
            if (pix_on) begin
              x_q      <= pix_x;
              y_q      <= pix_y;
              colour_q <= pix_colour;
            end
            if ((col_q == col_last) && (row_q == row_last)) begin
              fin_q <= 1'b1;
            end else if (col_q == col_last) begin
              col_q <= '0;
              row_q <= row_q + 7'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign plot      = plot_q;
  assign done      = done_q;
  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;

endmodule
